// File: rtl/scie_fir_issuer.sv
// rtl/scie_fir_issuer.sv - SCIE COEF/PUSH/READ issuer for the FIR accelerator; optional SCIE_ISSUER_PERF_EN adds perf counters
module scie_fir_issuer #(
  parameter int XLEN       = 32,
  parameter int NTAPS      = 5,
  parameter int GAP_CYCLES = 1,
  parameter int RD_LATENCY = 1,
  localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [IW-1:0]   cfg_idx,
  input  logic [XLEN-1:0] cfg_data,
  input  logic            smp_valid,
  output logic            smp_ready,
  input  logic [XLEN-1:0] smp_data,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [XLEN-1:0] res_data,
  output logic            busy,
  output logic            io_valid,
  output logic [31:0]     io_insn,
  output logic [XLEN-1:0] io_rs1,
  output logic [XLEN-1:0] io_rs2,
  input  logic [XLEN-1:0] io_rd
`ifdef SCIE_ISSUER_PERF_EN
  ,
  output logic [31:0]     perf_insn_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  localparam logic [31:0] OP_COEF = 32'h0000_000B;
  localparam logic [31:0] OP_PUSH = 32'h0000_002B;
  localparam logic [31:0] OP_READ = 32'h0000_005B;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COEF,
    S_PUSH,
    S_GAP,
    S_READ,
    S_WAIT,
    S_OUT
  } state_t;

  state_t          state, state_n;
  logic [3:0]      cnt, cnt_n;
  logic            io_valid_n;
  logic [31:0]     io_insn_n;
  logic [XLEN-1:0] io_rs1_n, io_rs2_n;
  logic            res_valid_n;
  logic [XLEN-1:0] res_data_n;

  // Handshake readies come straight from the state; cfg wins a tie in IDLE
  assign cfg_ready = (state == S_IDLE);
  assign smp_ready = (state == S_IDLE) && !cfg_valid;
  assign busy      = (state != S_IDLE);

  // Next state plus the values the registered io_*/res_* outputs take on entry
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    io_valid_n  = 1'b0;
    io_insn_n   = '0;
    io_rs1_n    = '0;
    io_rs2_n    = '0;
    res_valid_n = res_valid;
    res_data_n  = res_data;
    case (state)
      S_IDLE: begin
        if (cfg_valid) begin
          state_n    = S_COEF;
          io_valid_n = 1'b1;
          io_insn_n  = OP_COEF;
          io_rs1_n   = cfg_data;
          io_rs2_n   = XLEN'(cfg_idx);
        end else if (smp_valid) begin
          state_n    = S_PUSH;
          io_valid_n = 1'b1;
          io_insn_n  = OP_PUSH;
          io_rs1_n   = smp_data;
        end
      end
      S_COEF: state_n = S_IDLE;
      S_PUSH: begin
        if (GAP_CYCLES == 0) begin
          state_n    = S_READ;
          io_valid_n = 1'b1;
          io_insn_n  = OP_READ;
        end else begin
          state_n = S_GAP;
          cnt_n   = 4'(GAP_CYCLES - 1);
        end
      end
      S_GAP: begin
        if (cnt == '0) begin
          state_n    = S_READ;
          io_valid_n = 1'b1;
          io_insn_n  = OP_READ;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_READ: begin
        state_n = S_WAIT;
        cnt_n   = 4'(RD_LATENCY - 1);
      end
      S_WAIT: begin
        // The last WAIT edge is exactly RD_LATENCY cycles after the READ cycle
        if (cnt == '0) begin
          state_n     = S_OUT;
          res_valid_n = 1'b1;
          res_data_n  = io_rd;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_OUT: begin
        if (res_ready) begin
          state_n     = S_IDLE;
          res_valid_n = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any sequence in flight
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      io_valid  <= 1'b0;
      io_insn   <= '0;
      io_rs1    <= '0;
      io_rs2    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      io_valid  <= io_valid_n;
      io_insn   <= io_insn_n;
      io_rs1    <= io_rs1_n;
      io_rs2    <= io_rs2_n;
      res_valid <= res_valid_n;
      res_data  <= res_data_n;
    end
  end

`ifdef SCIE_ISSUER_PERF_EN
  // Free-running wrap-around counters of issued instructions and result stalls
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_insn_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (io_valid) begin
        perf_insn_cnt <= perf_insn_cnt + 32'd1;
      end
      if (state == S_OUT && !res_ready) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_scie_fir_issuer.sv
// tb/tb_scie_fir_issuer.sv - bench for scie_fir_issuer (instance 0 default params, instance 1 GAP_CYCLES=0 RD_LATENCY=3)
module tb_scie_fir_issuer;

  localparam logic [31:0] OP_COEF = 32'h0000_000B;
  localparam logic [31:0] OP_PUSH = 32'h0000_002B;
  localparam logic [31:0] OP_READ = 32'h0000_005B;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        cfg_valid [2];
  logic        cfg_ready [2];
  logic [2:0]  cfg_idx   [2];
  logic [31:0] cfg_data  [2];
  logic        smp_valid [2];
  logic        smp_ready [2];
  logic [31:0] smp_data  [2];
  logic        res_valid [2];
  logic        res_ready [2];
  logic [31:0] res_data  [2];
  logic        busy      [2];
  logic        io_valid  [2];
  logic [31:0] io_insn   [2];
  logic [31:0] io_rs1    [2];
  logic [31:0] io_rs2    [2];
  logic [31:0] io_rd     [2];
`ifdef SCIE_ISSUER_PERF_EN
  logic [31:0] perf_insn  [2];
  logic [31:0] perf_stall [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    scie_fir_issuer #(
      .XLEN(32), .NTAPS(5),
      .GAP_CYCLES((g == 0) ? 1 : 0),
      .RD_LATENCY((g == 0) ? 1 : 3)
    ) u_dut (
      .clock(clock), .reset(reset),
      .cfg_valid(cfg_valid[g]), .cfg_ready(cfg_ready[g]),
      .cfg_idx(cfg_idx[g]), .cfg_data(cfg_data[g]),
      .smp_valid(smp_valid[g]), .smp_ready(smp_ready[g]), .smp_data(smp_data[g]),
      .res_valid(res_valid[g]), .res_ready(res_ready[g]), .res_data(res_data[g]),
      .busy(busy[g]),
      .io_valid(io_valid[g]), .io_insn(io_insn[g]),
      .io_rs1(io_rs1[g]), .io_rs2(io_rs2[g]), .io_rd(io_rd[g])
`ifdef SCIE_ISSUER_PERF_EN
      , .perf_insn_cnt(perf_insn[g]), .perf_stall_cnt(perf_stall[g])
`endif
    );
  end

  function automatic int gap_of(input int k);
    return (k == 0) ? 1 : 0;
  endfunction
  function automatic int rdl_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Issued-instruction log plus accelerator model: READ returns the sample
  // pushed before the latest PUSH, visible on io_rd only at the capture edge
  typedef struct {
    int          k;
    int          cyc;
    logic [31:0] insn;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } ev_t;
  ev_t         ev_q[$];
  int          cd     [2] = '{0, 0};
  logic [31:0] prev_s [2] = '{0, 0};
  logic [31:0] cur_s  [2] = '{0, 0};
  logic [31:0] rd_val [2] = '{0, 0};

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      if (io_valid[k] === 1'b1) ev_q.push_back('{k, cyc, io_insn[k], io_rs1[k], io_rs2[k]});
      if (reset) begin
        cd[k] = 0;
      end else begin
        if (cd[k] != 0) cd[k] = cd[k] - 1;
        if (io_valid[k] === 1'b1 && io_insn[k] == OP_PUSH) begin
          prev_s[k] = cur_s[k];
          cur_s[k]  = io_rs1[k];
        end
        if (io_valid[k] === 1'b1 && io_insn[k] == OP_READ) begin
          rd_val[k] = prev_s[k];
          cd[k]     = rdl_of(k) + 1;
        end
      end
      io_rd[k] = (cd[k] == 1) ? rd_val[k] : $urandom;
    end
  end

  int ev_rd = 0;

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_ev(input int k, input string nm, input int c,
                           input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    tests++;
    if (ev_rd >= ev_q.size()) begin
      fails++;
      $display("FAIL %s: nothing issued, expected insn %0h at cycle %0d", nm, insn, c);
    end else begin
      ev_t e;
      e = ev_q[ev_rd];
      ev_rd++;
      if (e.k != k || e.cyc != c || e.insn != insn || e.rs1 != rs1 || e.rs2 != rs2) begin
        fails++;
        $display("FAIL %s: got dut%0d cyc %0d insn %0h rs1 %0h rs2 %0h, expected dut%0d cyc %0d insn %0h rs1 %0h rs2 %0h",
                 nm, e.k, e.cyc, e.insn, e.rs1, e.rs2, k, c, insn, rs1, rs2);
      end
    end
  endtask

  task automatic expect_none(input string nm);
    chk(nm, 32'(ev_q.size() - ev_rd), 32'd0);
    ev_rd = ev_q.size();
  endtask

  task automatic send_cfg(input int k, input logic [2:0] idx, input logic [31:0] data,
                          input logic [31:0] exp_rs2);
    int c0;
`ifdef SCIE_ISSUER_PERF_EN
    logic [31:0] p0;
    p0 = perf_insn[k];
`endif
    tick();
    cfg_valid[k] = 1'b1; cfg_idx[k] = idx; cfg_data[k] = data;
    #1;
    chk("cfg_ready idle", 32'(cfg_ready[k]), 32'd1);
    c0 = cyc;
    tick();
    cfg_valid[k] = 1'b0;
    chk("busy in coef", 32'(busy[k]), 32'd1);
    tick();
    chk("busy after coef", 32'(busy[k]), 32'd0);
    expect_ev(k, "coef issue", c0 + 1, OP_COEF, data, exp_rs2);
    expect_none("coef single issue");
`ifdef SCIE_ISSUER_PERF_EN
    chk("perf_insn coef", perf_insn[k] - p0, 32'd1);
`endif
  endtask

  task automatic send_sample(input int k, input logic [31:0] s, input logic [31:0] exp,
                             input int stall, input bit with_cfg,
                             input logic [2:0] cidx, input logic [31:0] cdata);
    int n, c0, cc;
    cc = 0;
`ifdef SCIE_ISSUER_PERF_EN
    logic [31:0] pi, ps;
    pi = perf_insn[k];
    ps = perf_stall[k];
`endif
    tick();
    smp_valid[k] = 1'b1; smp_data[k] = s;
    if (with_cfg) begin
      cfg_valid[k] = 1'b1; cfg_idx[k] = cidx; cfg_data[k] = cdata;
      #1;
      chk("prio smp_ready low", 32'(smp_ready[k]), 32'd0);
      chk("prio cfg_ready high", 32'(cfg_ready[k]), 32'd1);
      cc = cyc;
      tick();
      cfg_valid[k] = 1'b0;
    end
    #1;
    n = 0;
    while (!smp_ready[k] && n < 20) begin
      tick();
      #1;
      n++;
    end
    chk("sample accepted", 32'(smp_ready[k]), 32'd1);
    c0 = cyc;
    if (with_cfg) chk("prio sample accept cycle", 32'(c0 - cc), 32'd2);
    tick();
    smp_valid[k] = 1'b0;
    chk("busy in push", 32'(busy[k]), 32'd1);
    n = 0;
    while (!res_valid[k] && n < 30) begin
      tick();
      n++;
    end
    chk("res_valid rose", 32'(res_valid[k]), 32'd1);
    chk("res_valid latency", 32'(cyc - c0), 32'(3 + gap_of(k) + rdl_of(k)));
    for (int i = 0; i < stall; i++) begin
      chk("bp res_valid held", 32'(res_valid[k]), 32'd1);
      chk("bp res_data held", res_data[k], exp);
      chk("bp smp_ready low", 32'(smp_ready[k]), 32'd0);
      tick();
    end
    res_ready[k] = 1'b1;
    chk("res_data", res_data[k], exp);
    tick();
    res_ready[k] = 1'b0;
    #1;
    chk("res_valid after handshake", 32'(res_valid[k]), 32'd0);
    chk("smp_ready after handshake", 32'(smp_ready[k]), 32'd1);
    if (with_cfg) expect_ev(k, "prio coef first", cc + 1, OP_COEF, cdata, 32'(cidx));
    expect_ev(k, "push issue", c0 + 1, OP_PUSH, s, 32'd0);
    expect_ev(k, "read issue", c0 + 2 + gap_of(k), OP_READ, 32'd0, 32'd0);
    expect_none("no extra issue");
`ifdef SCIE_ISSUER_PERF_EN
    chk("perf_insn sample", perf_insn[k] - pi, with_cfg ? 32'd3 : 32'd2);
    chk("perf_stall", perf_stall[k] - ps, 32'(stall));
`endif
  endtask

  task automatic reset_seq(input int k, input logic [31:0] s, input bit in_gap);
    int c0;
    tick();
    smp_valid[k] = 1'b1; smp_data[k] = s;
    #1;
    chk("rst smp_ready", 32'(smp_ready[k]), 32'd1);
    c0 = cyc;
    tick();
    smp_valid[k] = 1'b0;
    chk("rst push pending", 32'(io_valid[k]), 32'd1);
    if (in_gap) begin
      tick();
      chk("rst in gap busy", 32'(busy[k]), 32'd1);
      chk("rst gap insn zero", io_insn[k], 32'd0);
    end
    reset = 1'b1;
    #1;
    chk("rst io_valid async", 32'(io_valid[k]), 32'd0);
    chk("rst busy async", 32'(busy[k]), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rst no result", 32'(res_valid[k]), 32'd0);
    end
    expect_ev(k, "rst push seen", c0 + 1, OP_PUSH, s, 32'd0);
    expect_none("rst no read");
`ifdef SCIE_ISSUER_PERF_EN
    chk("rst perf_insn cleared", perf_insn[k], 32'd0);
`endif
  endtask

  typedef struct {
    logic [2:0]  idx;
    logic [31:0] data;
    logic [31:0] exp_rs2;
  } cfg_vec_t;
  typedef struct {
    logic [31:0] s;
    logic [31:0] exp_res;
    int          stall;
  } smp_vec_t;

  cfg_vec_t    cfg_tab [6];
  smp_vec_t    smp_tab [3];
  logic [31:0] last_s  [2] = '{0, 0};

  initial begin
    logic [2:0]  ri;
    logic [31:0] rd, rs;
    int          rk;
    cfg_tab[0] = '{3'd0, 32'd4193776, 32'd0};
    cfg_tab[1] = '{3'd1, 32'd213188,  32'd1};
    cfg_tab[2] = '{3'd2, 32'd104368,  32'd2};
    cfg_tab[3] = '{3'd3, 32'd3111167, 32'd3};
    cfg_tab[4] = '{3'd4, 32'd2030295, 32'd4};
    cfg_tab[5] = '{3'd7, 32'hDEAD_BEEF, 32'd7};
    smp_tab[0] = '{32'd323244,     32'd0,       0};
    smp_tab[1] = '{32'd6076607,    32'd323244,  10};
    smp_tab[2] = '{32'hFFFF_FFF0,  32'd6076607, 0};

    for (int k = 0; k < 2; k++) begin
      cfg_valid[k] = 1'b0; cfg_idx[k] = '0; cfg_data[k] = '0;
      smp_valid[k] = 1'b0; smp_data[k] = '0; res_ready[k] = 1'b0;
    end
    reset = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      chk("reset io_valid", 32'(io_valid[k]), 32'd0);
      chk("reset io_insn", io_insn[k], 32'd0);
      chk("reset io_rs1", io_rs1[k], 32'd0);
      chk("reset io_rs2", io_rs2[k], 32'd0);
      chk("reset res_valid", 32'(res_valid[k]), 32'd0);
      chk("reset res_data", res_data[k], 32'd0);
      chk("reset busy", 32'(busy[k]), 32'd0);
      chk("reset cfg_ready", 32'(cfg_ready[k]), 32'd1);
      chk("reset smp_ready", 32'(smp_ready[k]), 32'd1);
    end
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) send_cfg(0, cfg_tab[i].idx, cfg_tab[i].data, cfg_tab[i].exp_rs2);
    for (int i = 0; i < 3; i++) begin
      send_sample(0, smp_tab[i].s, smp_tab[i].exp_res, smp_tab[i].stall, 1'b0, 3'd0, 32'd0);
      last_s[0] = smp_tab[i].s;
    end

    send_sample(0, 32'd777, last_s[0], 0, 1'b1, 3'd2, 32'd55);
    last_s[0] = 32'd777;

    reset_seq(0, 32'd424242, 1'b1);
    last_s[0] = 32'd424242;
    reset_seq(0, 32'd999, 1'b0);
    last_s[0] = 32'd999;
    send_sample(0, 32'd31337, last_s[0], 0, 1'b0, 3'd0, 32'd0);
    last_s[0] = 32'd31337;

    send_cfg(1, 3'd3, 32'd3111167, 32'd3);
    for (int i = 0; i < 3; i++) begin
      send_sample(1, smp_tab[i].s, smp_tab[i].exp_res, smp_tab[i].stall, 1'b0, 3'd0, 32'd0);
      last_s[1] = smp_tab[i].s;
    end

    for (int i = 0; i < 20; i++) begin
      rk = int'($urandom_range(0, 1));
      ri = 3'($urandom_range(0, 7));
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        send_cfg(rk, ri, rd, 32'(ri));
      end else begin
        rs = $urandom;
        send_sample(rk, rs, last_s[rk], int'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0), ri, rd);
        last_s[rk] = rs;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

endmodule
